// File: rtl/adder_share_ctrl_pkg.sv
// Shared definitions for the shared-adder controller.
//   state_e : controller FSM encoding (IDLE=0, CALC=1, HOLD=2)
//   OpW     : operand / result width of the shared adder
package adder_share_ctrl_pkg;

    localparam int unsigned OpW = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StHold = 2'd2
    } state_e;

endpackage

// File: rtl/adder8.sv
// 8-bit adder with two's-complement overflow flag. Carry-out is not reported.
//   a_i, b_i : operands
//   sum_o    : (a_i + b_i) mod 256
//   ovf_o    : signed overflow of the add
module adder8
    import adder_share_ctrl_pkg::*;
(
    input  logic [OpW-1:0] a_i,
    input  logic [OpW-1:0] b_i,
    output logic [OpW-1:0] sum_o,
    output logic           ovf_o
);

    always_comb begin
        sum_o = a_i + b_i;
        // Overflow only when both operands share a sign and the result flips it.
        ovf_o = (a_i[OpW-1] == b_i[OpW-1]) && (sum_o[OpW-1] != a_i[OpW-1]);
    end

endmodule

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr_i and wraps; the first asserted request wins.
//   req_i      : request vector
//   ptr_i      : index with highest priority this cycle
//   grant_o    : one-hot grant (all zero when no request)
//   grant_id_o : index of the granted requester (0 when no request)
//   any_o      : at least one request present
module adder_share_ctrl_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_id_o,
    output logic               any_o
);

    always_comb begin
        int unsigned idx;
        grant_o    = '0;
        grant_id_o = '0;
        any_o      = 1'b0;
        idx        = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr_i) + i) % NUM_REQ;
            if (!any_o && req_i[idx]) begin
                any_o        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_id_o   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one adder8 between NUM_REQ requesters with round-robin arbitration.
// One add in flight at a time: IDLE (accept) -> CALC (add, register result) -> HOLD (wait for
// consumer) -> IDLE.
//   clk, rst_n     : clock, asynchronous active-low reset
//   req_valid/a/b  : per-requester operands, requester i at [8*i+7:8*i]
//   req_ready      : one-hot accept, only in IDLE
//   rsp_*          : registered result, held until rsp_ready
//   ovf_count      : saturating count of delivered overflow results
//   busy           : FSM not in IDLE
module adder_share_ctrl
    import adder_share_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [OpW*NUM_REQ-1:0] req_a,
    input  logic [OpW*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [OpW-1:0]         rsp_sum,
    output logic                   rsp_overflow,
    input  logic                   rsp_ready,
    output logic [CNT_W-1:0]       ovf_count,
    output logic                   busy
);

    state_e           state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [OpW-1:0]   op_a_q, op_a_d;
    logic [OpW-1:0]   op_b_q, op_b_d;
    logic [ID_W-1:0]  op_id_q, op_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [OpW-1:0]   rsp_sum_q, rsp_sum_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_any;
    logic [OpW-1:0]     add_sum;
    logic               add_ovf;

    adder_share_ctrl_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i      (req_valid),
        .ptr_i      (rr_ptr_q),
        .grant_o    (grant),
        .grant_id_o (grant_id),
        .any_o      (grant_any)
    );

    adder8 u_adder (
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_ovf_d   = rsp_ovf_q;
        ovf_count_d = ovf_count_q;

        case (state_q)
            StIdle: begin
                if (grant_any) begin
                    op_a_d   = req_a[OpW*32'(grant_id) +: OpW];
                    op_b_d   = req_b[OpW*32'(grant_id) +: OpW];
                    op_id_d  = grant_id;
                    // Granted requester drops to lowest priority.
                    rr_ptr_d = (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                rsp_sum_d   = add_sum;
                rsp_ovf_d   = add_ovf;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = StHold;
            end
            StHold: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_ovf_q && (ovf_count_q != {CNT_W{1'b1}})) begin
                        ovf_count_d = ovf_count_q + CNT_W'(1);
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_ovf_q   <= 1'b0;
            ovf_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_ovf_q   <= rsp_ovf_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    // Grant is combinational; gating with rst_n keeps req_ready low while reset is held.
    assign req_ready    = (rst_n && (state_q == StIdle)) ? grant : '0;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_sum      = rsp_sum_q;
    assign rsp_overflow = rsp_ovf_q;
    assign ovf_count    = ovf_count_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_adder_share_ctrl.sv
module tb_adder_share_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_sum;
    logic        rsp_overflow;
    logic        rsp_ready;
    logic [15:0] ovf_count;
    logic        busy;

    int checks = 0;
    int errors = 0;

    adder_share_ctrl #(
        .NUM_REQ (4),
        .ID_W    (2),
        .CNT_W   (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_sum      (rsp_sum),
        .rsp_overflow (rsp_overflow),
        .rsp_ready    (rsp_ready),
        .ovf_count    (ovf_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction from a single requester with the consumer ready after one HOLD cycle.
    task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_sum, input logic exp_ovf,
                          input logic [15:0] exp_cnt);
        req_a[8*id +: 8] = a;
        req_b[8*id +: 8] = b;
        req_valid[id]    = 1'b1;
        #1;
        chk("grant", 32'(req_ready), 32'(4'b0001 << id));
        tick();
        req_valid = '0;
        chk("calc_busy", 32'(busy), 32'd1);
        chk("calc_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(rsp_id), 32'(id));
        chk("rsp_sum", 32'(rsp_sum), 32'(exp_sum));
        chk("rsp_ovf", 32'(rsp_overflow), 32'(exp_ovf));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("ovf_count", 32'(ovf_count), 32'(exp_cnt));
    endtask

    initial begin
        logic [1:0] rr_exp [5];
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #3;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        chk("rst_rsp_ovf", 32'(rsp_overflow), 32'd0);
        chk("rst_ovf_count", 32'(ovf_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        req_valid = 4'hF;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_req_ready", 32'(req_ready), 32'd0);

        // Normal, overflow and boundary sums
        run_op(0, 8'h10, 8'h20, 8'h30, 1'b0, 16'd0);
        run_op(1, 8'h7F, 8'h01, 8'h80, 1'b1, 16'd1);
        run_op(2, 8'h80, 8'h80, 8'h00, 1'b1, 16'd2);
        run_op(3, 8'hFF, 8'h01, 8'h00, 1'b0, 16'd2);
        run_op(0, 8'h00, 8'h00, 8'h00, 1'b0, 16'd2);
        run_op(1, 8'h7F, 8'h80, 8'hFF, 1'b0, 16'd2);

        // Backpressure: rr_ptr is 2 after the last grant to id 1
        req_a[23:16] = 8'h01;
        req_b[23:16] = 8'h02;
        req_valid[2] = 1'b1;
        #1;
        chk("bp_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'hF;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_sum", 32'(rsp_sum), 32'h03);
            chk("bp_rsp_id", 32'(rsp_id), 32'd2);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_no_bypass", 32'(req_ready), 32'd0);
        tick();
        rsp_ready = 1'b0;
        chk("bp_done_valid", 32'(rsp_valid), 32'd0);
        chk("bp_next_grant", 32'(req_ready), 32'b1000);
        req_valid = '0;
        #1;

        // Reset mid-operation while in CALC
        req_a[15:8]  = 8'h7F;
        req_b[15:8]  = 8'h7F;
        req_valid[1] = 1'b1;
        #1;
        chk("mid_grant", 32'(req_ready), 32'b0010);
        tick();
        chk("mid_calc_busy", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_sum", 32'(rsp_sum), 32'd0);
        chk("mid_rst_ovf_count", 32'(ovf_count), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 32'(rsp_valid), 32'd0);

        // Round-robin with all requesters held valid; sum for id i is 0x11*(i+1)
        req_a     = {8'h04, 8'h03, 8'h02, 8'h01};
        req_b     = {8'h40, 8'h30, 8'h20, 8'h10};
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(4'b0001 << rr_exp[k]));
            tick();
            tick();
            chk("rr_rsp_id", 32'(rsp_id), 32'(rr_exp[k]));
            chk("rr_rsp_sum", 32'(rsp_sum), 32'(8'h11 * (rr_exp[k] + 1)));
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
        req_valid = '0;
        chk("rr_ovf_count", 32'(ovf_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
